// File: rtl/transceive.sv
// transceive: 8N1 UART loopback. The receiver deserializes bytes from rxd and
// hands them over a valid/ready handshake (dat/stb/rdy) to a transmitter that
// re-serializes them on txd. err flags framing errors and overruns.
//
// Both FSMs share the same state names:
//   state | meaning
//   IDLE  | rx: waiting for a synchronized falling edge / tx: rdy=1, waiting for stb
//   START | rx: counting to mid start bit      / tx: driving start bit (0)
//   DATA  | rx: sampling 8 data bits mid-bit   / tx: driving d[0]..d[7]
//   STOP  | rx: counting to mid stop bit       / tx: driving stop bit (1)
//
// Bit period DIV = FREQUENCY/BAUDRATE (truncated) must be at least 4.
module transceive #(
  parameter int BAUDRATE  = 115200,
  parameter int FREQUENCY = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] dat,
  output logic       stb,
  output logic       rdy,
  output logic       err
);

  localparam int DIV  = FREQUENCY / BAUDRATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          rx_state;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_sh;
  logic            rx_s1, rx_s2, rx_d;

  state_t          tx_state;
  logic [CW-1:0]   tx_cnt;
  logic [2:0]      tx_bit;
  logic [7:0]      tx_sh;

  logic            fall;
  logic            xfer;

  assign fall = rx_d & ~rx_s2;
  assign xfer = stb & rdy;

  // rxd synchronizer plus edge-history flop. These reset low so that a line
  // held low through reset cannot look like a start edge: the receiver only
  // arms once it has seen rxd high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b0;
      rx_s2 <= 1'b0;
      rx_d  <= 1'b0;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Receiver FSM: mid-bit sampling with a down-counter, output byte register
  // and handshake/error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      dat      <= '0;
      stb      <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (xfer) stb <= 1'b0;
      case (rx_state)
        IDLE: begin
          if (fall) begin
            rx_state <= START;
            rx_cnt   <= HALF_M1;
          end
        end
        START: begin
          if (rx_cnt == '0) begin
            if (rx_s2) begin
              rx_state <= IDLE;
            end else begin
              rx_state <= DATA;
              rx_cnt   <= DIV_M1;
              rx_bit   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        DATA: begin
          if (rx_cnt == '0) begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= DIV_M1;
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= STOP;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        STOP: begin
          if (rx_cnt == '0) begin
            rx_state <= IDLE;
            if (rx_s2) begin
              dat <= rx_sh;
              stb <= 1'b1;
              // A byte still pending and not consumed this cycle is lost.
              err <= stb & ~rdy;
            end else begin
              err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // Transmitter FSM: latches dat on transfer and shifts it out LSB first,
  // txd and rdy both registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      txd      <= 1'b1;
      rdy      <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          if (xfer) begin
            tx_sh    <= dat;
            txd      <= 1'b0;
            rdy      <= 1'b0;
            tx_cnt   <= DIV_M1;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_cnt == '0) begin
            txd      <= tx_sh[0];
            tx_cnt   <= DIV_M1;
            tx_bit   <= '0;
            tx_state <= DATA;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= DIV_M1;
            tx_bit <= tx_bit + 1'b1;
            if (tx_bit == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= STOP;
            end else begin
              txd   <= tx_sh[1];
              tx_sh <= {1'b0, tx_sh[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        STOP: begin
          if (tx_cnt == '0) begin
            tx_state <= IDLE;
            rdy      <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_transceive.sv
// Testbench for transceive: drives 8N1 frames on rxd, decodes txd with an
// independent frame monitor and compares against a queue of expected bytes.
module tb_transceive;

  localparam int BAUD = 100000;
  localparam int FREQ = 1600000;
  localparam int DIV  = FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       txd;
  logic [7:0] dat;
  logic       stb;
  logic       rdy;
  logic       err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_q[$];
  int         mon_bad = 0;
  int         rdy_falls = 0;
  logic       rdy_prev = 1'b1;
  bit         stb_seen = 0;
  logic       model_err = 1'b0;

  logic [7:0] mb;
  bit         mok;
  logic [7:0] got;
  logic [7:0] b;
  bit         ok;
  bit         txd_low;
  int         r0;

  transceive #(.BAUDRATE(BAUD), .FREQUENCY(FREQ)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .txd(txd),
    .dat(dat), .stb(stb), .rdy(rdy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame on rxd; called right after a negedge, returns at the end of the stop bit.
  task automatic send_frame(input logic [7:0] v, input logic sb);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = v[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = sb;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic wait_echo(output logic [7:0] g, output bit k);
    k = 0;
    g = 8'h00;
    for (int n = 0; n < 30 * DIV; n++) begin
      if (mon_q.size() > 0) begin
        g = mon_q.pop_front();
        k = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_txd"}, 32'(txd), 32'd1);
    check({tag, "_rdy"}, 32'(rdy), 32'd1);
    check({tag, "_stb"}, 32'(stb), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_dat"}, 32'(dat), 32'd0);
  endtask

  task automatic loopback(input string tag, input bit fixed);
    logic [7:0] v;
    logic [7:0] g;
    bit k;
    logic [7:0] seed [4];
    seed[0] = 8'hA5; seed[1] = 8'h00; seed[2] = 8'hFF; seed[3] = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      v = (fixed && i < 4) ? seed[i] : 8'($urandom_range(0, 255));
      send_frame(v, 1'b1);
      exp_q.push_back(v);
      model_err = 1'b0;
      wait_echo(g, k);
      check({tag, "_echo_seen"}, 32'(k), 32'd1);
      check({tag, "_echo_byte"}, 32'(g), 32'(exp_q.pop_front()));
      check({tag, "_err"}, 32'(err), 32'(model_err));
    end
  endtask

  // txd frame decoder: sample mid-bit relative to the first low sample.
  initial forever begin
    @(negedge clk);
    if (rst === 1'b1 && txd === 1'b0) begin
      mok = 1;
      repeat (DIV / 2) @(negedge clk);
      if (txd !== 1'b0) mok = 0;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        mb[i] = txd;
      end
      repeat (DIV) @(negedge clk);
      if (txd !== 1'b1) mok = 0;
      if (rst === 1'b1) begin
        mon_q.push_back(mb);
        if (!mok) mon_bad++;
      end
    end
  end

  // Handshake observation: transmitter acceptances and any stb activity.
  always @(negedge clk) begin
    if (rst === 1'b1 && rdy_prev === 1'b1 && rdy === 1'b0) rdy_falls++;
    rdy_prev = rdy;
    if (stb === 1'b1) stb_seen = 1;
  end

  initial begin
    rxd = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst0");
    rst = 1'b1;
    repeat (4 * DIV) @(negedge clk);

    loopback("loop", 1'b1);

    // Reset in the middle of a receive frame, after four data bits.
    repeat (12 * DIV) @(negedge clk);
    b = 8'($urandom_range(0, 255));
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rst = 1'b0;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("rstmid");
    rst = 1'b1;
    model_err = 1'b0;
    repeat (20 * DIV) @(negedge clk);
    check("rstmid_no_stale", 32'(mon_q.size()), 32'd0);
    check("rstmid_stb", 32'(stb), 32'd0);
    loopback("post_rst", 1'b0);

    // Framing error, then recovery.
    repeat (12 * DIV) @(negedge clk);
    send_frame(8'h55, 1'b0);
    model_err = 1'b1;
    repeat (15 * DIV) @(negedge clk);
    check("frame_no_echo", 32'(mon_q.size()), 32'd0);
    check("frame_err", 32'(err), 32'(model_err));
    check("frame_stb", 32'(stb), 32'd0);
    send_frame(8'h12, 1'b1);
    model_err = 1'b0;
    wait_echo(got, ok);
    check("recover_seen", 32'(ok), 32'd1);
    check("recover_byte", 32'(got), 32'h12);
    check("recover_err", 32'(err), 32'(model_err));

    // Short low glitch.
    repeat (12 * DIV) @(negedge clk);
    stb_seen = 0;
    txd_low = 0;
    rxd = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    rxd = 1'b1;
    for (int n = 0; n < 3 * DIV; n++) begin
      @(negedge clk);
      if (txd !== 1'b1) txd_low = 1;
    end
    check("glitch_stb", 32'(stb_seen), 32'd0);
    check("glitch_txd", 32'(txd_low), 32'd0);
    check("glitch_err", 32'(err), 32'd0);
    check("glitch_no_echo", 32'(mon_q.size()), 32'd0);

    // Back-to-back frames without an idle gap.
    repeat (4 * DIV) @(negedge clk);
    r0 = rdy_falls;
    send_frame(8'h01, 1'b1); exp_q.push_back(8'h01);
    send_frame(8'h80, 1'b1); exp_q.push_back(8'h80);
    send_frame(8'hFF, 1'b1); exp_q.push_back(8'hFF);
    model_err = 1'b0;
    for (int n = 0; n < 40 * DIV && mon_q.size() < 3; n++) @(negedge clk);
    check("b2b_count", 32'(mon_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      got = (mon_q.size() > 0) ? mon_q.pop_front() : 8'hxx;
      check("b2b_byte", 32'(got), 32'(exp_q.pop_front()));
    end
    repeat (2 * DIV) @(negedge clk);
    check("b2b_rdy_falls", 32'(rdy_falls - r0), 32'd3);
    check("b2b_rdy_idle", 32'(rdy), 32'd1);
    check("b2b_err", 32'(err), 32'(model_err));
    check("tx_frame_shape", 32'(mon_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
